// File: rtl/psr_cond_unit_if.sv
// psr_cond_unit_if: condition query request/response handshake between the control FSM (master) and psr_cond_unit (slave)
//   cond_valid/cond_code/cond_ready : query request, accepted on cond_valid & cond_ready
//   res_valid/res_taken/res_ready   : query response, consumed on res_valid & res_ready
interface psr_cond_unit_if;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  modport master (output cond_valid, cond_code, res_ready, input cond_ready, res_valid, res_taken);
  modport slave (input cond_valid, cond_code, res_ready, output cond_ready, res_valid, res_taken);
endinterface

// File: rtl/psr_cond_unit.sv
// psr_cond_unit: CR16 processor status register {N,Z,F,L,C} and branch/jump/Scond condition evaluator
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   alu_op    : ALU opcode selecting which flags flag_we may update
//   alu_psr   : ALU flag vector {N,Z,F,L,C}
//   flag_we   : commit masked ALU flags
//   psr_we    : full PSR write (LPR), wins over flag_we
//   psr_wdata : data for psr_we
//   psr_out   : registered PSR
//   cq        : condition query handshake (slave side)
//   Build option PSR_FWD_EN: evaluate accepted queries against the forwarded post-write PSR,
//   giving fixed 1-cycle latency; otherwise a write in the acceptance cycle detours through HOLD.
module psr_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] alu_op,
  input  logic [4:0] alu_psr,
  input  logic       flag_we,
  input  logic       psr_we,
  input  logic [4:0] psr_wdata,
  output logic [4:0] psr_out,
  psr_cond_unit_if.slave cq
);
  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;
  state_t     state_q;
  logic [4:0] psr_q, psr_d, mask;
  logic       ready_q, valid_q, taken_q;
`ifndef PSR_FWD_EN
  logic [3:0] code_q;
`endif
  // Even codes test a flag (or flag combination), the odd partner is its complement.
  function automatic logic eval(input logic [3:0] c, input logic [4:0] p);
    logic base;
    case (c[3:1])
      3'd0:    base = p[3];
      3'd1:    base = p[0];
      3'd2:    base = p[1];
      3'd3:    base = p[4];
      3'd4:    base = p[2];
      3'd5:    base = ~p[1] & ~p[3];
      3'd6:    base = ~p[4] & ~p[3];
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction
  always_comb begin
    mask = alu_op == 4'b0000 ? 5'b00101 :
           (alu_op == 4'b0100 || alu_op == 4'b0110) ? 5'b01011 :
           alu_op == 4'b0101 ? 5'b00001 :
           alu_op == 4'b1000 ? 5'b11010 : 5'b00000;
    psr_d = psr_we ? psr_wdata : flag_we ? (psr_q & ~mask) | (alu_psr & mask) : psr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      psr_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
`ifndef PSR_FWD_EN
      code_q  <= '0;
`endif
    end else begin
      psr_q <= psr_d;
      case (state_q)
        IDLE: if (cq.cond_valid) begin
          ready_q <= 1'b0;
`ifdef PSR_FWD_EN
          taken_q <= eval(cq.cond_code, psr_d);
          valid_q <= 1'b1;
          state_q <= RESP;
`else
          code_q <= cq.cond_code;
          // A write in this cycle lands in psr_q at this edge; HOLD evaluates it next cycle.
          if (flag_we | psr_we) state_q <= HOLD;
          else begin
            taken_q <= eval(cq.cond_code, psr_q);
            valid_q <= 1'b1;
            state_q <= RESP;
          end
`endif
        end
`ifndef PSR_FWD_EN
        HOLD: begin
          taken_q <= eval(code_q, psr_q);
          valid_q <= 1'b1;
          state_q <= RESP;
        end
`endif
        RESP: if (cq.res_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign psr_out       = psr_q;
  assign cq.cond_ready = ready_q;
  assign cq.res_valid  = valid_q;
  assign cq.res_taken  = taken_q;
endmodule

// File: tb/tb_psr_cond_unit.sv
// tb_psr_cond_unit: directed bench for psr_cond_unit with a cycle-level reference model and per-cycle compare
module tb_psr_cond_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] alu_op = '0;
  logic [4:0] alu_psr = '0;
  logic       flag_we = 1'b0;
  logic       psr_we = 1'b0;
  logic [4:0] psr_wdata = '0;
  logic [4:0] psr_out;
  int vectors = 0;
  int miscompares = 0;
  psr_cond_unit_if cq();
  psr_cond_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .alu_psr(alu_psr), .flag_we(flag_we),
    .psr_we(psr_we), .psr_wdata(psr_wdata), .psr_out(psr_out), .cq(cq)
  );
  always #5 clk = ~clk;
  // reference model state
  bit [4:0] m_mask [16];
  bit [4:0] m_psr = '0;
  bit       m_idle = 1'b1;
  bit       m_valid = 1'b0;
  bit       m_taken = 1'b0;
  bit       m_pend = 1'b0;
  initial begin
    foreach (m_mask[i]) m_mask[i] = '0;
    m_mask[0] = 5'b00101;  // ADD : C,F
    m_mask[4] = 5'b01011;  // SUB : C,L,Z
    m_mask[5] = 5'b00001;  // ADDU: C
    m_mask[6] = 5'b01011;  // SUBU: C,L,Z
    m_mask[8] = 5'b11010;  // CMP : N,L,Z
  end
  function automatic bit m_cond(input int c, input bit [4:0] p);
    bit n, z, f, l, cy;
    {n, z, f, l, cy} = p;
    case (c)
      0: return z;    1: return !z;   2: return cy;   3: return !cy;
      4: return l;    5: return !l;   6: return n;    7: return !n;
      8: return f;    9: return !f;
      10: return !l && !z;  11: return l || z;
      12: return !n && !z;  13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  always @(posedge clk or posedge reset) begin
    bit [4:0] np;
    int lat;
    if (reset) begin
      m_psr = '0; m_idle = 1'b1; m_valid = 1'b0; m_taken = 1'b0;
    end else begin
      np = m_psr;
      if (psr_we) np = psr_wdata;
      else if (flag_we) for (int i = 0; i < 5; i++) if (m_mask[alu_op][i]) np[i] = alu_psr[i];
`ifdef PSR_FWD_EN
      lat = 1;
`else
      lat = (flag_we || psr_we) ? 2 : 1;
`endif
      if (m_valid) begin
        if (cq.res_ready) begin m_valid = 1'b0; m_idle = 1'b1; end
      end else if (!m_idle) begin
        m_valid = 1'b1; m_taken = m_pend;
      end else if (cq.cond_valid) begin
        m_idle = 1'b0;
        m_pend = m_cond(int'(cq.cond_code), np);
        if (lat == 1) begin m_valid = 1'b1; m_taken = m_pend; end
      end
      m_psr = np;
    end
  end
  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    chk("psr_out", psr_out, m_psr);
    chk("cond_ready", {4'b0, cq.cond_ready}, {4'b0, m_idle});
    chk("res_valid", {4'b0, cq.res_valid}, {4'b0, m_valid});
    if (m_valid) chk("res_taken", {4'b0, cq.res_taken}, {4'b0, m_taken});
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask
  task automatic query(input logic [3:0] code, output logic taken, output int lat);
    cq.cond_valid = 1'b1;
    cq.cond_code = code;
    tick();
    cq.cond_valid = 1'b0;
    flag_we = 1'b0;
    psr_we = 1'b0;
    lat = 1;
    while (!cq.res_valid && lat < 6) begin
      tick();
      lat++;
    end
    if (!cq.res_valid) chk("query_timeout", {4'b0, cq.res_valid}, 5'b00001);
    taken = cq.res_taken;
    tick();
  endtask
  initial begin
    logic t;
    int lat;
    int exp_lat;
    cq.cond_valid = 1'b0;
    cq.cond_code = '0;
    cq.res_ready = 1'b1;
    tick();
    do_reset();
    chk("rst_psr", psr_out, 5'b00000);
    chk("rst_valid", {4'b0, cq.res_valid}, 5'b0);
    chk("rst_taken", {4'b0, cq.res_taken}, 5'b0);
    chk("rst_ready", {4'b0, cq.cond_ready}, 5'b1);
    tick();
    query(4'h0, t, lat);
    chk("eq_lat", lat[4:0], 5'd1);
    chk("eq_taken", {4'b0, t}, 5'b0);
    chk("eq_psr", psr_out, 5'b00000);
    chk("ready_after", {4'b0, cq.cond_ready}, 5'b1);
    alu_op = 4'b1000; alu_psr = 5'b11010; flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    chk("cmp_psr", psr_out, 5'b11010);
    query(4'h6, t, lat); chk("gt_taken", {4'b0, t}, 5'b1);
    query(4'hA, t, lat); chk("lo_taken", {4'b0, t}, 5'b0);
    query(4'hB, t, lat); chk("hs_taken", {4'b0, t}, 5'b1);
    tick();
    do_reset();
    tick();
    alu_op = 4'b0000; alu_psr = 5'b11111; flag_we = 1'b1;
    tick();
    chk("add_psr", psr_out, 5'b00101);
    alu_op = 4'b0001;
    tick();
    flag_we = 1'b0;
    chk("nop_op_psr", psr_out, 5'b00101);
    psr_we = 1'b1; psr_wdata = 5'b01000;
    flag_we = 1'b1; alu_op = 4'b0000; alu_psr = 5'b00001;
`ifdef PSR_FWD_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    query(4'h0, t, lat);
    chk("same_cyc_psr", psr_out, 5'b01000);
    chk("same_cyc_taken", {4'b0, t}, 5'b1);
    chk("same_cyc_lat", lat[4:0], exp_lat[4:0]);
    alu_op = 4'b0001; alu_psr = 5'b11111; flag_we = 1'b1;
    query(4'h8, t, lat);
    chk("noop_we_taken", {4'b0, t}, 5'b0);
    chk("noop_we_lat", lat[4:0], exp_lat[4:0]);
    cq.res_ready = 1'b0;
    cq.cond_valid = 1'b1; cq.cond_code = 4'h0;
    tick();
    cq.cond_valid = 1'b0; cq.cond_code = 4'h1;
    for (int i = 0; i < 5; i++) begin
      flag_we = 1'b1;
      alu_op = (i % 2 == 0) ? 4'b1000 : 4'b0100;
      alu_psr = 5'(i * 7);
      tick();
      chk("hold_valid", {4'b0, cq.res_valid}, 5'b1);
      chk("hold_taken", {4'b0, cq.res_taken}, 5'b1);
      chk("hold_ready", {4'b0, cq.cond_ready}, 5'b0);
    end
    flag_we = 1'b0;
    cq.res_ready = 1'b1;
    tick();
    chk("release_ready", {4'b0, cq.cond_ready}, 5'b1);
    chk("release_valid", {4'b0, cq.res_valid}, 5'b0);
    psr_we = 1'b1; psr_wdata = 5'b10110;
    tick();
    psr_we = 1'b0;
    for (int c = 0; c < 16; c++) query(4'(c), t, lat);
    chk("sweep_lt", {4'b0, m_cond(12, psr_out)}, 5'b0);
    psr_we = 1'b1; psr_wdata = 5'b11111;
    tick();
    psr_we = 1'b0;
    cq.res_ready = 1'b0;
    cq.cond_valid = 1'b1; cq.cond_code = 4'hE;
    tick();
    cq.cond_valid = 1'b0;
    chk("resp_valid", {4'b0, cq.res_valid}, 5'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {4'b0, cq.res_valid}, 5'b0);
    chk("async_psr", psr_out, 5'b00000);
    chk("async_ready", {4'b0, cq.cond_ready}, 5'b1);
    reset = 1'b0;
    cq.res_ready = 1'b1;
    tick();
    query(4'h3, t, lat);
    chk("post_rst_cc", {4'b0, t}, 5'b1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
